knn_topk: RTL
=============

# knn_topk

Parametrised k-nearest-neighbour search engine for the KNN peripheral. It latches a test point and streams in labelled training points over a valid/ready handshake. For each point it computes the exact squared Euclidean distance in a two-stage pipeline and maintains a sorted list of the K closest points with their labels. The software-facing register wrapper starts a search, then reads back neighbours by index after `done`.

## Interface
- `DATA_W`, 32: signed coordinate width.
- `K`, 4: number of neighbours kept, 1..16.
- `LABEL_W`, 8: label width.
- `CNT_W`, 16: width of the training-point counter.
- `DIST_W` (derived, not overridable) = 2*DATA_W+1: exact squared-distance width.

Ports:
- `clk` input 1: clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `KNN_ENABLE` input 1: global enable; low freezes all state except reset.
- `start` input 1: begin a search (sampled in IDLE or DONE).
- `test_x`, `test_y` input DATA_W each: signed test point, latched on accepted `start`.
- `pt_valid` input 1: training point present.
- `pt_ready` output 1: engine accepts a point this cycle.
- `pt_x`, `pt_y` input DATA_W each: signed training point.
- `pt_label` input LABEL_W: training label.
- `pt_last` input 1: marks the final training point of a search.
- `busy` output 1: high in RUN and DRAIN.
- `done` output 1: one-cycle pulse when the list is final.
- `nbr_sel` input $clog2(K) (min 1): neighbour index to read; 0 = nearest.
- `nbr_dist` output DIST_W: distance of the selected entry.
- `nbr_label` output LABEL_W: label of the selected entry.
- `nbr_valid` output 1: selected entry holds a point.
- `pt_count` output CNT_W: training points accepted this search, saturating.

## Operation
- States are IDLE, RUN, DRAIN and DONE. Reset enters IDLE.
- **IDLE/DONE:** when `start`=1 and `KNN_ENABLE`=1, latch the test point, invalidate all K entries, clear `pt_count` and go to RUN. In DONE the list stays readable until the next start.
- **RUN:** `pt_ready` = `KNN_ENABLE`. A point is accepted when `pt_valid` and `pt_ready` are both high. When the accepted point has `pt_last`=1, go to DRAIN. `start` is ignored in RUN and DRAIN.
- **DRAIN:** `pt_ready`=0. Wait until the pipeline is empty, pulse `done`, then go to DONE.
- **Stage 1:** dx = pt_x − test_x and dy = pt_y − test_y, both sign-extended to DATA_W+1 bits, so no overflow.
- **Stage 2:** dist = dx² + dy², unsigned, DIST_W bits; the result is exact for all inputs.
- **Stage 3 (insert):** invalid entries count as infinite distance.
  - The new point goes at the first index i where dist < entry[i].dist, or where entry i is invalid.
  - Entries i..K−2 shift down one place; entry K−1 is dropped.
  - If no such index exists, the list is unchanged.
  - Ties are stable: an earlier-arrived point ranks ahead of a later one with equal distance.
- **`pt_count`:** increments on each accept and saturates at 2^CNT_W−1.
- **Readback:** `nbr_*` is a combinational mux of the list by `nbr_sel`. `nbr_sel` ≥ K returns zeros.

## Timing
- Values on reset: `pt_ready`=0, `busy`=0, `done`=0, `pt_count`=0, all entries invalid, so `nbr_valid`=0, `nbr_dist`=0 and `nbr_label`=0.
- A start sampled at edge 0 puts the engine in RUN from cycle 1, with `pt_ready`=1 if enabled.
- A point accepted at edge t:
  - its diffs are registered at t+1;
  - its distance is registered at t+2;
  - the list is updated at t+3.
- Throughput is one point per cycle with no bubbles.
- If `pt_last` is accepted at edge t, `done` is high during the cycle after edge t+3, and the state is DONE from edge t+4. `busy` falls with `done` rising.
- While `KNN_ENABLE`=0, the pipeline registers, list, state and counter all hold, and `done` is held off.
- When enable returns, operation resumes exactly where it stopped, with no lost or duplicated points.
- Async reset in any state clears everything immediately. A point in flight is discarded.

## Test plan
- **Basic search, K=4.** Test point (0,0). Points (3,4,L1), (1,1,L2), (10,0,L3), (0,2,L4), (5,5,L5, last).
  - Required list: dists 2/L2, 4/L4, 25/L1, 50/L5; L3 is dropped.
  - `done` pulses 4 cycles after the last accept; `pt_count`=5.
- **Width extremes, DATA_W=32.** Test point (−2^31, −2^31), point (2^31−1, 2^31−1).
  - Required `nbr_dist[0]` = 2·(2^32−1)² exactly.
- **Ties.** Three points, each at distance 25, labels 7, 8, 9 in arrival order.
  - Required entries 0..2 hold labels 7, 8, 9; entry 3 has `nbr_valid`=0.
- **Partial fill and readback range.** Two points only.
  - Required `nbr_valid` = 1,1,0,0.
  - `nbr_sel`=3 returns zeros.
- **Enable gating.**
  - Drop `KNN_ENABLE` for 5 cycles mid-stream with `pt_valid` held high.
    - Required: no accepts occur and the list is unchanged.
    - Required after resume: final result identical to the ungated run, and `done` is delayed by exactly 5 cycles.
  - `start` while in RUN is ignored.
- **Reset mid-search, then restart.**
  - Assert `rst`=0 during RUN with points in flight.
    - Required: `busy`=0, all entries invalid, `pt_count`=0 immediately.
  - A new start followed by one point yields only that point at entry 0.

Source files
------------

// File: rtl/knn_topk.sv
// k-nearest-neighbour search engine: streams labelled training points,
// computes exact squared Euclidean distance to a latched test point in a
// two-stage pipeline and keeps a stable, sorted list of the K closest points.
module knn_topk #(
  parameter  int DATA_W  = 32,
  parameter  int K       = 4,
  parameter  int LABEL_W = 8,
  parameter  int CNT_W   = 16,
  localparam int DIST_W  = 2*DATA_W+1,
  localparam int SEL_W   = (K > 1) ? $clog2(K) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      KNN_ENABLE,
  input  logic                      start,
  input  logic signed [DATA_W-1:0]  test_x,
  input  logic signed [DATA_W-1:0]  test_y,
  input  logic                      pt_valid,
  output logic                      pt_ready,
  input  logic signed [DATA_W-1:0]  pt_x,
  input  logic signed [DATA_W-1:0]  pt_y,
  input  logic [LABEL_W-1:0]        pt_label,
  input  logic                      pt_last,
  output logic                      busy,
  output logic                      done,
  input  logic [SEL_W-1:0]          nbr_sel,
  output logic [DIST_W-1:0]         nbr_dist,
  output logic [LABEL_W-1:0]        nbr_label,
  output logic                      nbr_valid,
  output logic [CNT_W-1:0]          pt_count
);

  localparam int NSEL = 1 << SEL_W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;
  logic   done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic signed [DATA_W-1:0] test_x_q, test_x_d, test_y_q, test_y_d;

  logic                      vld_p0_q, vld_p0_d;
  logic signed [DATA_W-1:0]  x_p0_q, x_p0_d, y_p0_q, y_p0_d;
  logic [LABEL_W-1:0]        lbl_p0_q, lbl_p0_d;

  logic                      vld_p1_q, vld_p1_d;
  logic signed [DATA_W:0]    dx_p1_q, dx_p1_d, dy_p1_q, dy_p1_d;
  logic [LABEL_W-1:0]        lbl_p1_q, lbl_p1_d;

  logic                      vld_p2_q, vld_p2_d;
  logic [DIST_W-1:0]         dist_p2_q, dist_p2_d;
  logic [LABEL_W-1:0]        lbl_p2_q, lbl_p2_d;

  logic [DIST_W-1:0]         ent_dist_q [K];
  logic [DIST_W-1:0]         ent_dist_d [K];
  logic [LABEL_W-1:0]        ent_lbl_q  [K];
  logic [LABEL_W-1:0]        ent_lbl_d  [K];
  logic [K-1:0]              ent_val_q, ent_val_d;

  logic [DIST_W-1:0]         rd_dist  [NSEL];
  logic [LABEL_W-1:0]        rd_lbl   [NSEL];
  logic [NSEL-1:0]           rd_val;

  logic accept;
  logic start_ok;

  // Counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Exact dx^2 + dy^2; squares of DATA_W+1-bit values fit in 2*DATA_W bits.
  function automatic logic [DIST_W-1:0] sq_dist(input logic signed [DATA_W:0] a,
                                                input logic signed [DATA_W:0] b);
    logic signed [2*DATA_W+1:0] ax, bx, sa, sb;
    ax = {{(DATA_W+1){a[DATA_W]}}, a};
    bx = {{(DATA_W+1){b[DATA_W]}}, b};
    sa = ax * ax;
    sb = bx * bx;
    return sa[DIST_W-1:0] + sb[DIST_W-1:0];
  endfunction

  assign accept   = (state_q == S_RUN) && KNN_ENABLE && pt_valid;
  assign start_ok = ((state_q == S_IDLE) || (state_q == S_DONE)) && start && KNN_ENABLE;
  assign pt_ready = (state_q == S_RUN) && KNN_ENABLE;
  assign busy     = (state_q == S_RUN) || ((state_q == S_DRAIN) && !done_q);
  assign done     = done_q && KNN_ENABLE;
  assign pt_count = cnt_q;

  // Search control: start, accept counting, drain detection and done pulse.
  always_comb begin
    state_d  = state_q;
    done_d   = done_q;
    cnt_d    = cnt_q;
    test_x_d = test_x_q;
    test_y_d = test_y_q;
    if (KNN_ENABLE) begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            test_x_d = test_x;
            test_y_d = test_y;
            cnt_d    = '0;
            state_d  = S_RUN;
          end
        end
        S_RUN: begin
          if (accept) begin
            cnt_d = sat_inc(cnt_q);
            if (pt_last) state_d = S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Stage 2 retires into the list on the same edge done rises.
          if (done_q) begin
            done_d  = 1'b0;
            state_d = S_DONE;
          end else if (!vld_p0_q && !vld_p1_q) begin
            done_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Pipeline next-state: capture, difference, squared distance; frozen when disabled.
  always_comb begin
    vld_p0_d  = vld_p0_q;
    x_p0_d    = x_p0_q;
    y_p0_d    = y_p0_q;
    lbl_p0_d  = lbl_p0_q;
    vld_p1_d  = vld_p1_q;
    dx_p1_d   = dx_p1_q;
    dy_p1_d   = dy_p1_q;
    lbl_p1_d  = lbl_p1_q;
    vld_p2_d  = vld_p2_q;
    dist_p2_d = dist_p2_q;
    lbl_p2_d  = lbl_p2_q;
    if (KNN_ENABLE) begin
      vld_p0_d = accept;
      if (accept) begin
        x_p0_d   = pt_x;
        y_p0_d   = pt_y;
        lbl_p0_d = pt_label;
      end
      vld_p1_d  = vld_p0_q;
      dx_p1_d   = {x_p0_q[DATA_W-1], x_p0_q} - {test_x_q[DATA_W-1], test_x_q};
      dy_p1_d   = {y_p0_q[DATA_W-1], y_p0_q} - {test_y_q[DATA_W-1], test_y_q};
      lbl_p1_d  = lbl_p0_q;
      vld_p2_d  = vld_p1_q;
      dist_p2_d = sq_dist(dx_p1_q, dy_p1_q);
      lbl_p2_d  = lbl_p1_q;
    end
  end

  // Sorted insert: first slot that is empty or strictly farther takes the point.
  always_comb begin
    logic              found;
    logic [DIST_W-1:0] prev_dist;
    logic [LABEL_W-1:0] prev_lbl;
    logic              prev_val;
    found     = 1'b0;
    prev_dist = '0;
    prev_lbl  = '0;
    prev_val  = 1'b0;
    ent_val_d = ent_val_q;
    for (int i = 0; i < K; i++) begin
      ent_dist_d[i] = ent_dist_q[i];
      ent_lbl_d[i]  = ent_lbl_q[i];
    end
    if (KNN_ENABLE) begin
      if (start_ok) begin
        ent_val_d = '0;
      end else if (vld_p2_q) begin
        for (int i = 0; i < K; i++) begin
          if (found) begin
            ent_dist_d[i] = prev_dist;
            ent_lbl_d[i]  = prev_lbl;
            ent_val_d[i]  = prev_val;
          end else if (!ent_val_q[i] || (dist_p2_q < ent_dist_q[i])) begin
            ent_dist_d[i] = dist_p2_q;
            ent_lbl_d[i]  = lbl_p2_q;
            ent_val_d[i]  = 1'b1;
            found         = 1'b1;
          end
          prev_dist = ent_dist_q[i];
          prev_lbl  = ent_lbl_q[i];
          prev_val  = ent_val_q[i];
        end
      end
    end
  end

  // Readback mux; out-of-range and empty entries read as zero.
  always_comb begin
    for (int i = 0; i < NSEL; i++) begin
      rd_dist[i] = '0;
      rd_lbl[i]  = '0;
      rd_val[i]  = 1'b0;
      if (i < K) begin
        if (ent_val_q[i]) begin
          rd_dist[i] = ent_dist_q[i];
          rd_lbl[i]  = ent_lbl_q[i];
          rd_val[i]  = 1'b1;
        end
      end
    end
    nbr_dist  = rd_dist[nbr_sel];
    nbr_label = rd_lbl[nbr_sel];
    nbr_valid = rd_val[nbr_sel];
  end

  // Control state: FSM, done pulse, counter, stage valids and entry valids.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      done_q    <= 1'b0;
      cnt_q     <= '0;
      vld_p0_q  <= 1'b0;
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      ent_val_q <= '0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      cnt_q     <= cnt_d;
      vld_p0_q  <= vld_p0_d;
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      ent_val_q <= ent_val_d;
    end
  end

  // Datapath registers; qualified by their valids so they need no reset.
  always_ff @(posedge clk) begin
    test_x_q  <= test_x_d;
    test_y_q  <= test_y_d;
    // stage p0: captured point
    x_p0_q    <= x_p0_d;
    y_p0_q    <= y_p0_d;
    lbl_p0_q  <= lbl_p0_d;
    // stage p1: coordinate differences
    dx_p1_q   <= dx_p1_d;
    dy_p1_q   <= dy_p1_d;
    lbl_p1_q  <= lbl_p1_d;
    // stage p2: squared distance
    dist_p2_q <= dist_p2_d;
    lbl_p2_q  <= lbl_p2_d;
    // list
    for (int i = 0; i < K; i++) begin
      ent_dist_q[i] <= ent_dist_d[i];
      ent_lbl_q[i]  <= ent_lbl_d[i];
    end
  end

endmodule
